// File: rtl/countdown_timer_bcd.sv
// rtl/countdown_timer_bcd.sv - HH:MM:SS BCD countdown timer; optional CDT_AUTO_RELOAD_EN reloads on expiry
module countdown_timer_bcd #(
    parameter int MAX_HRS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic        run,
    input  logic        load,
    input  logic [23:0] ld_value,
    output logic [3:0]  hr_tens,
    output logic [3:0]  hr_ones,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        zero,
    output logic        done,
    output logic        ld_err
);

    logic [3:0] hr_tens_q,  hr_tens_d;
    logic [3:0] hr_ones_q,  hr_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       done_q,     done_d;
    logic       ld_err_q,   ld_err_d;

    logic [3:0] ld_hr_t, ld_hr_o, ld_mn_t, ld_mn_o, ld_sc_t, ld_sc_o;
    logic [7:0] ld_hours;
    logic       ld_valid;
    logic       tick;
    logic       at_last_sec;

    assign ld_hr_t = ld_value[23:20];
    assign ld_hr_o = ld_value[19:16];
    assign ld_mn_t = ld_value[15:12];
    assign ld_mn_o = ld_value[11:8];
    assign ld_sc_t = ld_value[7:4];
    assign ld_sc_o = ld_value[3:0];

    assign ld_hours = ({4'd0, ld_hr_t} * 8'd10) + {4'd0, ld_hr_o};

    assign ld_valid = (ld_hr_t <= 4'd9) && (ld_hr_o <= 4'd9)
                   && (ld_mn_t <= 4'd5) && (ld_mn_o <= 4'd9)
                   && (ld_sc_t <= 4'd5) && (ld_sc_o <= 4'd9)
                   && (ld_hours <= 8'(MAX_HRS));

    assign zero = (hr_tens_q == 4'd0) && (hr_ones_q == 4'd0)
               && (min_tens_q == 4'd0) && (min_ones_q == 4'd0)
               && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

    assign at_last_sec = (hr_tens_q == 4'd0) && (hr_ones_q == 4'd0)
                      && (min_tens_q == 4'd0) && (min_ones_q == 4'd0)
                      && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);

    // A tick coincident with load is dropped, not deferred.
    assign tick = enb && run && !load && !zero;

`ifdef CDT_AUTO_RELOAD_EN
    logic [23:0] reload_q, reload_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= 24'd0;
        end else begin
            reload_q <= reload_d;
        end
    end

    always_comb begin
        reload_d = reload_q;
        if (load && ld_valid) begin
            reload_d = ld_value;
        end
    end
`endif

    always_comb begin
        hr_tens_d  = hr_tens_q;
        hr_ones_d  = hr_ones_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        done_d     = 1'b0;
        ld_err_d   = 1'b0;

        if (load) begin
            if (ld_valid) begin
                hr_tens_d  = ld_hr_t;
                hr_ones_d  = ld_hr_o;
                min_tens_d = ld_mn_t;
                min_ones_d = ld_mn_o;
                sec_tens_d = ld_sc_t;
                sec_ones_d = ld_sc_o;
            end else begin
                ld_err_d = 1'b1;
            end
        end else if (tick) begin
            if (at_last_sec) begin
                done_d = 1'b1;
`ifdef CDT_AUTO_RELOAD_EN
                hr_tens_d  = reload_q[23:20];
                hr_ones_d  = reload_q[19:16];
                min_tens_d = reload_q[15:12];
                min_ones_d = reload_q[11:8];
                sec_tens_d = reload_q[7:4];
                sec_ones_d = reload_q[3:0];
`else
                sec_ones_d = 4'd0;
`endif
            end else if (sec_ones_q != 4'd0) begin
                sec_ones_d = sec_ones_q - 4'd1;
            end else begin
                // Borrow ripples up until a non-zero digit absorbs it.
                sec_ones_d = 4'd9;
                if (sec_tens_q != 4'd0) begin
                    sec_tens_d = sec_tens_q - 4'd1;
                end else begin
                    sec_tens_d = 4'd5;
                    if (min_ones_q != 4'd0) begin
                        min_ones_d = min_ones_q - 4'd1;
                    end else begin
                        min_ones_d = 4'd9;
                        if (min_tens_q != 4'd0) begin
                            min_tens_d = min_tens_q - 4'd1;
                        end else begin
                            min_tens_d = 4'd5;
                            if (hr_ones_q != 4'd0) begin
                                hr_ones_d = hr_ones_q - 4'd1;
                            end else begin
                                hr_ones_d = 4'd9;
                                hr_tens_d = hr_tens_q - 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_tens_q  <= 4'd0;
            hr_ones_q  <= 4'd0;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            done_q     <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            hr_tens_q  <= hr_tens_d;
            hr_ones_q  <= hr_ones_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            done_q     <= done_d;
            ld_err_q   <= ld_err_d;
        end
    end

    assign hr_tens  = hr_tens_q;
    assign hr_ones  = hr_ones_q;
    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign done     = done_q;
    assign ld_err   = ld_err_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb/tb_countdown_timer_bcd.sv - directed self-checking bench for countdown_timer_bcd
module tb_countdown_timer_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb = 1'b0;
    logic        run = 1'b0;
    logic        load = 1'b0;
    logic [23:0] ld_value = 24'd0;
    logic [3:0]  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic        zero, done, ld_err;
    logic [23:0] digits;

    int errors = 0;
    int checks = 0;

    countdown_timer_bcd #(.MAX_HRS(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .run      (run),
        .load     (load),
        .ld_value (ld_value),
        .hr_tens  (hr_tens),
        .hr_ones  (hr_ones),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (zero),
        .done     (done),
        .ld_err   (ld_err)
    );

    always #5 clk = ~clk;

    assign digits = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply current inputs across one rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [23:0] v);
        ld_value = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_tick();
        enb = 1'b1;
        step();
        enb = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_digits", digits, 24'h000000);
        check("rst_zero",   {23'd0, zero},   24'd1);
        check("rst_done",   {23'd0, done},   24'd0);
        check("rst_ld_err", {23'd0, ld_err}, 24'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        do_load(24'h000100);
        check("load_000100", digits, 24'h000100);
        check("load_zero_lo", {23'd0, zero}, 24'd0);
        run = 1'b1;
        do_tick();
        check("tick_000059", digits, 24'h000059);
        check("tick_done_lo", {23'd0, done}, 24'd0);

        do_load(24'h100000);
        do_tick();
        check("borrow_095959", digits, 24'h095959);

        do_load(24'h000002);
        do_tick();
        check("exp_000001", digits, 24'h000001);
        check("exp_done_pre", {23'd0, done}, 24'd0);
        do_tick();
        check("exp_000000", digits, 24'h000000);
        check("exp_zero", {23'd0, zero}, 24'd1);
        check("exp_done_hi", {23'd0, done}, 24'd1);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check("hold_zero_digits", digits, 24'h000000);
            check("hold_zero_done", {23'd0, done}, 24'd0);
        end

        do_load(24'h000000);
        check("load_zero_done", {23'd0, done}, 24'd0);

        do_load(24'h000010);
        do_load(24'h130000);
        check("bad_hrs_err", {23'd0, ld_err}, 24'd1);
        check("bad_hrs_hold", digits, 24'h000010);
        step();
        check("err_one_cycle", {23'd0, ld_err}, 24'd0);
        do_load(24'h006000);
        check("bad_min_err", {23'd0, ld_err}, 24'd1);
        check("bad_min_hold", digits, 24'h000010);
        do_load(24'h00000A);
        check("bad_sec_err", {23'd0, ld_err}, 24'd1);
        do_load(24'h125959);
        check("max_ok_err", {23'd0, ld_err}, 24'd0);
        check("max_ok_digits", digits, 24'h125959);
        do_tick();
        check("max_tick", digits, 24'h125958);

        enb = 1'b1;
        do_load(24'h000005);
        enb = 1'b0;
        check("load_drops_tick", digits, 24'h000005);
        run = 1'b0;
        do_tick();
        do_tick();
        check("run_lo_hold", digits, 24'h000005);
        run = 1'b1;
        do_tick();
        check("run_hi_count", digits, 24'h000004);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_digits", digits, 24'h000000);
        check("async_rst_zero", {23'd0, zero}, 24'd1);
        @(negedge clk);
        rst = 1'b0;
        do_tick();
        check("post_rst_idle", digits, 24'h000000);
        check("post_rst_done", {23'd0, done}, 24'd0);

`ifdef CDT_AUTO_RELOAD_EN
        do_load(24'h000003);
        do_tick();
        do_tick();
        do_tick();
        check("reload_done", {23'd0, done}, 24'd1);
        check("reload_digits", digits, 24'h000003);
        do_tick();
        check("reload_continue", digits, 24'h000002);
        check("reload_done_lo", {23'd0, done}, 24'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
